// File: rtl/cassette_fsk_modulator_pkg.sv
// Shared types and default tone constants for the cassette FSK output path.
package cassette_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, DATA = 2'd2} state_t;

   localparam int ACC_W_DEF = 24;
   localparam int STEP0_DEF = 402;
   localparam int STEP1_DEF = 1610;
endpackage

// File: rtl/fsk_phase_acc.sv
// Phase accumulator: every overflow (wrap) toggles the square output s.
module fsk_phase_acc #(
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [ACC_W-1:0] step,
   output logic             wrap,
   output logic             s
);
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   assign sum  = {1'b0, acc} + {1'b0, step};
   assign wrap = en & sum[ACC_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
         s   <= 1'b1;
      end else if (clear) begin
         acc <= '0;
         s   <= 1'b1;
      end else begin
         if (en)   acc <= sum[ACC_W-1:0];
         if (wrap) s   <= ~s;
      end
   end
endmodule

// File: rtl/cassette_fsk_modulator.sv
// Byte-serial FSK modulator: LSB-first bits as phase-continuous square tones, plus leader tone.
module cassette_fsk_modulator import cassette_pkg::*; #(
   parameter int ACC_W       = ACC_W_DEF,
   parameter int STEP0       = STEP0_DEF,
   parameter int STEP1       = STEP1_DEF,
   parameter int CYC_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic       tone_req,
   input  logic       tone_freq,
   output logic       s,
   output logic       busy,
   output logic       bit_strobe
);
   localparam logic [ACC_W-1:0] S0       = ACC_W'(STEP0);
   localparam logic [ACC_W-1:0] S1       = ACC_W'(STEP1);
   localparam logic [4:0]       CAR_LAST = 5'(2 * CYC_PER_BIT - 1);

   state_t           state, state_n;
   logic [7:0]       shifter, shifter_n, hold_data;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [4:0]       car_cnt, car_cnt_n;
   logic             tone_sel, tone_sel_n;
   logic             hold_full, accept, drain, bit_end, wrap;
   logic [ACC_W-1:0] step;

   assign accept = byte_valid & byte_ready;
   assign busy   = (state != IDLE);
   // Step source only moves at bit ends / cycle boundaries, keeping phase continuous.
   assign step   = (state == DATA) ? (shifter[0] ? S1 : S0) : (tone_sel ? S1 : S0);

   fsk_phase_acc #(.ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .reset (reset),
      .clear (state == IDLE),
      .en    (busy),
      .step  (step),
      .wrap  (wrap),
      .s     (s)
   );

   always_comb begin
      state_n    = state;
      shifter_n  = shifter;
      bit_cnt_n  = bit_cnt;
      car_cnt_n  = car_cnt;
      tone_sel_n = tone_sel;
      drain      = 1'b0;
      bit_end    = 1'b0;
      case (state)
         IDLE: begin
            if (hold_full) begin
               state_n   = DATA;
               shifter_n = hold_data;
               bit_cnt_n = '0;
               car_cnt_n = '0;
               drain     = 1'b1;
            end else if (tone_req) begin
               state_n    = TONE;
               tone_sel_n = tone_freq;
            end
         end
         DATA: begin
            if (wrap) begin
               if (car_cnt == CAR_LAST) begin
                  bit_end   = 1'b1;
                  car_cnt_n = '0;
                  if (bit_cnt != 3'd7) begin
                     shifter_n = shifter >> 1;
                     bit_cnt_n = bit_cnt + 3'd1;
                  end else if (hold_full) begin
                     shifter_n = hold_data;
                     bit_cnt_n = '0;
                     drain     = 1'b1;
                  end else if (tone_req) begin
                     state_n    = TONE;
                     tone_sel_n = tone_freq;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  car_cnt_n = car_cnt + 5'd1;
               end
            end
         end
         TONE: begin
            // A wrap while s is low is the 0->1 cycle boundary.
            if (wrap && !s) begin
               if (hold_full) begin
                  state_n   = DATA;
                  shifter_n = hold_data;
                  bit_cnt_n = '0;
                  car_cnt_n = '0;
                  drain     = 1'b1;
               end else if (!tone_req) begin
                  state_n = IDLE;
               end else begin
                  tone_sel_n = tone_freq;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shifter    <= '0;
         bit_cnt    <= '0;
         car_cnt    <= '0;
         tone_sel   <= 1'b0;
         hold_full  <= 1'b0;
         hold_data  <= '0;
         byte_ready <= 1'b1;
         bit_strobe <= 1'b0;
      end else begin
         state      <= state_n;
         shifter    <= shifter_n;
         bit_cnt    <= bit_cnt_n;
         car_cnt    <= car_cnt_n;
         tone_sel   <= tone_sel_n;
         bit_strobe <= bit_end;
         if (accept) begin
            hold_full <= 1'b1;
            hold_data <= byte_data;
         end else if (drain) begin
            hold_full <= 1'b0;
         end
         // Drops on accept; rises one clk after a drain empties the holding register.
         byte_ready <= accept ? 1'b0 : ~hold_full;
      end
   end
endmodule

// File: tb/tb_cassette_fsk_modulator.sv
// Directed bench: half periods are 8 clks (logic 0) and 4 clks (logic 1).
module tb_cassette_fsk_modulator;
   localparam int ACC_W = 7, STEP0 = 16, STEP1 = 32;

   logic       clk = 1'b0, reset = 1'b1;
   logic [7:0] byte_data = 8'h00;
   logic       byte_valid = 1'b0, tone_req = 1'b0, tone_freq = 1'b0;
   logic       byte_ready, s, busy, bit_strobe;

   cassette_fsk_modulator #(.ACC_W(ACC_W), .STEP0(STEP0), .STEP1(STEP1), .CYC_PER_BIT(1)) dut (
      .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .tone_req(tone_req), .tone_freq(tone_freq),
      .s(s), .busy(busy), .bit_strobe(bit_strobe));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   strobes[$];
   int   toggles[$];
   logic prev_s = 1'b1;
   always @(negedge clk) begin
      if (bit_strobe) strobes.push_back(cyc);
      if (s !== prev_s) toggles.push_back(cyc);
      prev_s = s;
   end

   int checks = 0, failures = 0;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   int acc_at;
   task automatic send(input logic [7:0] d);
      int n;
      byte_data  = d;
      byte_valid = 1'b1;
      n = 0;
      while (!byte_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=%0d expected=<400", n);
      end
      acc_at = cyc + 1;
      @(negedge clk);
   endtask

   function automatic int qs(input int i);
      return (i < strobes.size()) ? strobes[i] : -1;
   endfunction
   function automatic int qt(input int i);
      return (i < toggles.size()) ? toggles[i] : -1;
   endfunction

   typedef struct packed {
      logic [7:0]      data;
      logic [7:0][7:0] per;   // per[i] = expected clks of bit i
   } vec_t;
   vec_t vecs[3];

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int a, e, base;
      int t5[6];
      vecs[0].data = 8'hA5; vecs[0].per = {8'd8, 8'd16, 8'd8, 8'd16, 8'd16, 8'd8, 8'd16, 8'd8};
      vecs[1].data = 8'h3C; vecs[1].per = {8'd16, 8'd16, 8'd8, 8'd8, 8'd8, 8'd8, 8'd16, 8'd16};
      vecs[2].data = 8'h80; vecs[2].per = {8'd8, {7{8'd16}}};
      t5 = '{8, 16, 20, 24, 28, 32};

      repeat (3) @(negedge clk);
      chk("rst_s", s, 1);
      chk("rst_ready", byte_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_strobe", bit_strobe, 0);
      reset = 1'b0;
      @(negedge clk);

      // reset mid-byte
      send(8'h00);
      byte_valid = 1'b0;
      a = acc_at;
      wait_until(a + 13);
      chk("pre_rst_s", s, 0);
      chk("pre_rst_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_s", s, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", byte_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      strobes.delete();
      toggles.delete();
      wait_until(cyc + 30);
      chk("post_rst_toggles", toggles.size(), 0);
      chk("post_rst_strobes", strobes.size(), 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_s", s, 1);

      // single bytes from IDLE
      for (int v = 0; v < 3; v++) begin
         strobes.delete();
         toggles.delete();
         send(vecs[v].data);
         byte_valid = 1'b0;
         base = acc_at + 1;
         wait_until(acc_at + 140);
         chk($sformatf("v%0d_nstrobe", v), strobes.size(), 8);
         for (int i = 0; i < 8; i++) begin
            base += int'(vecs[v].per[i]);
            chk($sformatf("v%0d_strobe%0d", v, i), qs(i), base);
         end
         chk($sformatf("v%0d_ntoggle", v), toggles.size(), 16);
         chk($sformatf("v%0d_idle_s", v), s, 1);
         chk($sformatf("v%0d_idle_busy", v), busy, 0);
      end

      // back-to-back 0x00, 0xFF with valid held
      strobes.delete();
      toggles.delete();
      send(8'h00);
      a = acc_at;
      send(8'hFF);
      byte_valid = 1'b0;
      chk("b2b_accept2", acc_at, a + 3);
      wait_until(a + 200);
      chk("b2b_nstrobe", strobes.size(), 16);
      e = a + 1;
      for (int i = 0; i < 16; i++) begin
         e += (i < 8) ? 16 : 8;
         chk($sformatf("b2b_strobe%0d", i), qs(i), e);
      end
      chk("b2b_idle_s", s, 1);

      // leader tone, high, dropped while s is low
      strobes.delete();
      toggles.delete();
      tone_freq = 1'b1;
      tone_req  = 1'b1;
      e = cyc + 1;
      wait_until(e + 45);
      chk("tone_mid_s", s, 0);
      tone_req = 1'b0;
      wait_until(e + 70);
      chk("tone_ntoggle", toggles.size(), 12);
      for (int i = 0; i < 12; i++) chk($sformatf("tone_tog%0d", i), qt(i), e + 4 * (i + 1));
      chk("tone_end_s", s, 1);
      chk("tone_end_busy", busy, 0);

      // tone_freq changed mid-cycle
      toggles.delete();
      tone_freq = 1'b0;
      tone_req  = 1'b1;
      e = cyc + 1;
      wait_until(e + 12);
      tone_freq = 1'b1;
      wait_until(e + 26);
      tone_req = 1'b0;
      wait_until(e + 50);
      chk("fchg_ntoggle", toggles.size(), 6);
      for (int i = 0; i < 6; i++) chk($sformatf("fchg_tog%0d", i), qt(i), e + t5[i]);
      chk("fchg_end_s", s, 1);

      // byte arriving during tone
      strobes.delete();
      toggles.delete();
      tone_freq = 1'b1;
      tone_req  = 1'b1;
      e = cyc + 1;
      wait_until(e + 9);
      send(8'h01);
      byte_valid = 1'b0;
      chk("tb_accept", acc_at, e + 10);
      wait_until(e + 150);
      chk("tb_resumed_busy", busy, 1);
      tone_req = 1'b0;
      wait_until(e + 180);
      chk("tb_nstrobe", strobes.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("tb_strobe%0d", i), qs(i), e + 24 + 16 * i);
      chk("tb_ntoggle", toggles.size(), 24);
      chk("tb_tog3", qt(3), e + 16);
      chk("tb_tog4", qt(4), e + 20);
      chk("tb_tog20", qt(20), e + 140);
      chk("tb_tog23", qt(23), e + 152);
      chk("tb_end_s", s, 1);
      chk("tb_end_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
